proc_instr_issuer: RTL and testbench
====================================

Name: proc_instr_issuer

Overview:
- Initiator side of the processor control FSM's `w`/`Done` handshake.
- Buffers instruction words from a host in a small FIFO and issues them one at a time: a single-cycle `w` pulse with F/Rx/Ry, plus the load operand on `ext_data`.
- Waits for `Done` before issuing the next instruction.
- Counts retired instructions and flags protocol errors (timeout, unexpected `Done`).

Parameters:
- DW, 8, width of the load-data operand / `ext_data`.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- TIMEOUT, 8, maximum cycles in WAIT without `Done` before error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  host instruction valid
- in_ready  out  1  FIFO can accept (= not full)
- in_instr  in  DW+6  {F[1:0], Rx[1:0], Ry[1:0], data[DW-1:0]} (F in MSBs)
- en  in  1  issue enable; low = no new issue, in-flight instruction still completes
- w  out  1  single-cycle start pulse to control FSM
- F  out  2  opcode: 00 load, 01 move, 10/11 add/sub
- Rx  out  2  destination register index
- Ry  out  2  source register index
- ext_data  out  DW  load operand for the external bus input
- Done  in  1  completion pulse from control FSM
- busy  out  1  instruction in flight (state WAIT)
- fifo_count  out  clog2(DEPTH+1)  occupied entries
- retired_cnt  out  8  instructions completed, wraps 255→0
- timeout_err  out  1  sticky: `Done` not seen within TIMEOUT cycles
- spurious_err  out  1  sticky: `Done` seen while not in WAIT

Behaviour:
- Reset (async, rst=1): FIFO empty; state IDLE. All of these are 0: w, F, Rx, Ry, ext_data, busy, fifo_count, retired_cnt, timeout_err, spurious_err. in_ready=1.
- All outputs are registered except `in_ready` (combinational from registered count).
- FIFO push: on an edge with in_valid && in_ready. Pop only as part of an issue. Push and pop may occur on the same edge; count is unchanged in that case.
- When full, in_ready=0 and in_valid is ignored. Pop never occurs when empty.
- State IDLE:
  - Issue condition: en && fifo_count≠0 at the edge.
  - On issue: pop the head; register F/Rx/Ry/ext_data from it; set w=1 for the next cycle; go to WAIT; clear the timeout counter.
- State WAIT:
  - w is 1 only in the first WAIT cycle, then 0.
  - F/Rx/Ry/ext_data stay stable until the next issue; they are not cleared on completion.
  - Timeout counter increments each WAIT cycle.
  - Done=1 at the edge: retired_cnt+1.
    - If en && FIFO non-empty: issue the next instruction on the same edge (back-to-back; w high the cycle after `Done`). Stay in WAIT with the counter cleared.
    - Otherwise go to IDLE.
  - No `Done` and counter reaches TIMEOUT-1: timeout_err←1, go to IDLE, retired_cnt unchanged. That instruction is dropped.
- Done=1 in IDLE: spurious_err←1; no other effect.
- Error flags are cleared only by rst. Issue continues after an error.
- `w` is never asserted while in WAIT except the issue cycle. It is therefore never re-pulsed while the FSM is busy, which would corrupt its latched Rx/Ry/F.
- Expected FSM latency from the w cycle I: load/move Done in cycle I+1; add/sub Done in cycle I+3.
- busy = (state==WAIT).
- en deasserted mid-WAIT: the current instruction completes normally; nothing further issues.
- Reset mid-operation: immediate clear as above. FIFO contents are discarded. The control FSM shares rst, so both ends return to idle together.

Test Plan:
- Load: push {00,10,00,0xA5} with en=1, FSM model Done one cycle after w → w high exactly one cycle with F=00, Rx=2, ext_data=0xA5; retired_cnt=1; busy low 1 cycle after Done.
- Back-to-back: push move {01,01,03} then add {10,00,01} before en → add's w appears the cycle after move's Done; add Done 3 cycles after its w; retired_cnt=2; w never high during the add's STEP cycles.
- FIFO full: en=0, push 5 words with DEPTH=4 → in_ready=0 after the 4th; 5th not accepted; fifo_count=4. Set en=1 → 4 issues in order, count decrements 4→0.
- Timeout: issue an add, withhold Done → timeout_err=1 after 8 WAIT cycles; state IDLE; retired_cnt unchanged; next queued word issues normally.
- Spurious and enable: Done pulse while idle → spurious_err=1. Deassert en during WAIT → current completes, no further w until en=1.
- Async reset while in WAIT with 3 queued → w=0, fifo_count=0, busy=0, retired_cnt=0, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/proc_instr_issuer.sv
// Instruction issuer: buffers host instruction words in a small FIFO and hands them
// one at a time to the processor control FSM over the w/Done handshake.
module proc_instr_issuer #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DW+5:0]                in_instr,
    input  logic                         en,
    output logic                         w,
    output logic [1:0]                   F,
    output logic [1:0]                   Rx,
    output logic [1:0]                   Ry,
    output logic [DW-1:0]                ext_data,
    input  logic                         Done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [7:0]                   retired_cnt,
    output logic                         timeout_err,
    output logic                         spurious_err
);

    localparam int IW = DW + 6;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [TW-1:0]  tmo_reg;
    logic           push, issue, retire, tmo_hit, spurious, have_work;
    logic [IW-1:0]  head;

    assign in_ready   = (count_reg != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign have_work  = en && (count_reg != '0);
    assign head       = mem[rd_ptr_reg];
    assign fifo_count = count_reg;
    assign busy       = (state_reg == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (have_work) state_next = WAIT;
            WAIT: begin
                if (Done) begin
                    if (!have_work) state_next = IDLE;
                end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Done takes priority over a timeout landing on the same edge.
    always_comb begin
        issue    = 1'b0;
        retire   = 1'b0;
        tmo_hit  = 1'b0;
        spurious = 1'b0;
        case (state_reg)
            IDLE: begin
                spurious = Done;
                issue    = have_work;
            end
            WAIT: begin
                if (Done) begin
                    retire = 1'b1;
                    issue  = have_work;
                end else begin
                    tmo_hit = (tmo_reg == TW'(TIMEOUT - 1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)  wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (issue) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, issue})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w            <= 1'b0;
            F            <= '0;
            Rx           <= '0;
            Ry           <= '0;
            ext_data     <= '0;
            tmo_reg      <= '0;
            retired_cnt  <= '0;
            timeout_err  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            w <= issue;
            if (issue) begin
                {F, Rx, Ry, ext_data} <= head;
                tmo_reg               <= '0;
            end else if (state_reg == WAIT) begin
                tmo_reg <= tmo_reg + TW'(1);
            end
            if (retire)   retired_cnt  <= retired_cnt + 8'd1;
            if (tmo_hit)  timeout_err  <= 1'b1;
            if (spurious) spurious_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proc_instr_issuer.sv
// Randomized bench for proc_instr_issuer: a queue-based reference model of the issue
// rules is stepped once per clock and every output is compared each cycle.
module tb_proc_instr_issuer;

    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int IW      = DW + 6;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int NCYC    = 2000;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  in_instr;
    logic           en;
    logic           w;
    logic [1:0]     F, Rx, Ry;
    logic [DW-1:0]  ext_data;
    logic           Done;
    logic           busy;
    logic [CW-1:0]  fifo_count;
    logic [7:0]     retired_cnt;
    logic           timeout_err, spurious_err;

    proc_instr_issuer #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .en(en), .w(w), .F(F), .Rx(Rx), .Ry(Ry),
        .ext_data(ext_data), .Done(Done), .busy(busy), .fifo_count(fifo_count),
        .retired_cnt(retired_cnt), .timeout_err(timeout_err),
        .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending instructions as a queue, in-flight flag, wait-cycle count.
    logic [IW-1:0] m_q[$];
    bit            m_wait;
    int            m_tmo;
    bit            m_w;
    logic [IW-1:0] m_out;
    int            m_ret;
    bit            m_terr, m_serr;

    function automatic void model_reset();
        m_q.delete();
        m_wait = 0; m_tmo = 0; m_w = 0; m_out = '0;
        m_ret = 0; m_terr = 0; m_serr = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [IW-1:0] d,
                                       input bit e, input bit dn);
        bit push, iss;
        push = v && (m_q.size() < DEPTH);
        iss  = 0;
        if (!m_wait) begin
            if (dn) m_serr = 1;
            iss = e && (m_q.size() != 0);
        end else if (dn) begin
            m_ret = (m_ret + 1) % 256;
            iss   = e && (m_q.size() != 0);
            if (!iss) m_wait = 0;
        end else if (m_tmo == TIMEOUT - 1) begin
            m_terr = 1;
            m_wait = 0;
        end else begin
            m_tmo++;
        end
        m_w = iss;
        if (iss) begin
            m_out  = m_q.pop_front();
            m_wait = 1;
            m_tmo  = 0;
        end
        if (push) m_q.push_back(d);
    endfunction

    task automatic check_all(input string pre);
        check({pre, ".in_ready"},     32'(in_ready),     32'(m_q.size() < DEPTH));
        check({pre, ".fifo_count"},   32'(fifo_count),   32'(m_q.size()));
        check({pre, ".w"},            32'(w),            32'(m_w));
        check({pre, ".F"},            32'(F),            32'(m_out[IW-1 -: 2]));
        check({pre, ".Rx"},           32'(Rx),           32'(m_out[IW-3 -: 2]));
        check({pre, ".Ry"},           32'(Ry),           32'(m_out[IW-5 -: 2]));
        check({pre, ".ext_data"},     32'(ext_data),     32'(m_out[DW-1:0]));
        check({pre, ".busy"},         32'(busy),         32'(m_wait));
        check({pre, ".retired_cnt"},  32'(retired_cnt),  32'(m_ret));
        check({pre, ".timeout_err"},  32'(timeout_err),  32'(m_terr));
        check({pre, ".spurious_err"}, 32'(spurious_err), 32'(m_serr));
    endtask

    int done_at;

    // Plays host and control FSM: Done 1 cycle after w for load/move, 3 for add/sub,
    // occasionally withheld (timeout) or injected on its own (spurious / early).
    task automatic drive_and_step(input int cyc);
        int phase, pv, pe;
        bit dn;
        phase = (cyc / 50) % 4;
        case (phase)
            0:       begin pv = 80; pe = 20;  end
            1:       begin pv = 50; pe = 90;  end
            2:       begin pv = 30; pe = 100; end
            default: begin pv = 90; pe = 60;  end
        endcase
        if (w === 1'b1) begin
            if ($urandom_range(0, 5) == 0) done_at = -1;
            else done_at = cyc + (F[1] ? 3 : 1);
        end
        dn       = (cyc == done_at) || ($urandom_range(0, 39) == 0);
        in_valid = ($urandom_range(0, 99) < pv);
        in_instr = IW'($urandom);
        en       = ($urandom_range(0, 99) < pe);
        Done     = dn;
        model_step(in_valid, in_instr, en, dn);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; en = 1'b0; Done = 1'b0;
        done_at = -1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        drive_and_step(0);
        for (int cyc = 1; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_all("run");
            if (cyc == 175 || cyc == 975) begin
                rst = 1'b1; in_valid = 1'b0; en = 1'b0; Done = 1'b0;
                #1;
                model_reset();
                done_at = -1;
                check_all("async_rst");
                @(negedge clk);
                check_all("rst_hold");
                rst = 1'b0;
            end
            drive_and_step(cyc);
        end
        @(negedge clk);
        check_all("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
